// File: rtl/apb_uart_cmd_master_if.sv
// Bus bundle for apb_uart_cmd_master: the UART byte handshakes plus the APB initiator signals.
interface apb_uart_cmd_master_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [7:0]            PWDATA;
  logic [7:0]            PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  rx_data, rx_valid, tx_ready, PRDATA, PREADY, PSLVERR,
    output tx_data, tx_valid, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, PRDATA, PREADY, PSLVERR,
    input  tx_data, tx_valid, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_uart_cmd_master.sv
// UART byte-command to APB initiator: one command byte (+ data byte for writes) -> one APB transfer -> status/data bytes.
// Optional macro APB_CMD_BYTE_TIMEOUT_EN adds a WAIT_DATA inter-byte timeout reported as status 0x18.
module apb_uart_cmd_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int BYTE_TIMEOUT   = 1000
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_uart_cmd_master_if.master bus,
  output logic                  busy,
  output logic                  cmd_drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_SETUP,
    S_ACCESS,
    S_RESP_STAT,
    S_RESP_DATA
  } state_t;

  localparam logic [7:0]  STAT_OK  = 8'h06;
  localparam logic [7:0]  STAT_ERR = 8'h15;
  localparam logic [7:0]  STAT_TO  = 8'h18;
  localparam logic [15:0] TO_LAST  = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [7:0]            r_wdata;
  logic [7:0]            r_rdata;
  logic [7:0]            r_status;
  logic [15:0]           r_tcnt;
  logic                  r_cmd_drop;
  logic                  w_drop;
  logic                  w_access_to;
  logic                  w_byte_to;

  // Counter value TO_LAST is the last ACCESS cycle allowed; 0 disables the abort.
  assign w_access_to = (TIMEOUT_CYCLES != 0) && (r_tcnt == TO_LAST);

`ifdef APB_CMD_BYTE_TIMEOUT_EN
  localparam logic [15:0] BYTE_LAST = 16'(BYTE_TIMEOUT - 1);
  logic [15:0] r_byte_cnt;

  assign w_byte_to = (r_state == S_WAIT_DATA) && !bus.rx_valid && (r_byte_cnt == BYTE_LAST);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_byte_cnt <= '0;
    end else if (r_state != S_WAIT_DATA) begin
      r_byte_cnt <= '0;
    end else if (!bus.rx_valid) begin
      r_byte_cnt <= r_byte_cnt + 16'd1;
    end
  end
`else
  localparam int unused_byte_timeout = BYTE_TIMEOUT;
  assign w_byte_to = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_drop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.rx_valid) w_next_state = bus.rx_data[7] ? S_WAIT_DATA : S_SETUP;
      end
      S_WAIT_DATA: begin
        if (bus.rx_valid) begin
          w_next_state = S_SETUP;
        end else if (w_byte_to) begin
          w_next_state = S_RESP_STAT;
          w_drop       = 1'b1;
        end
      end
      S_SETUP: begin
        w_next_state = S_ACCESS;
        w_drop       = bus.rx_valid;
      end
      S_ACCESS: begin
        if (bus.PREADY || w_access_to) w_next_state = S_RESP_STAT;
        w_drop = bus.rx_valid;
      end
      S_RESP_STAT: begin
        if (bus.tx_ready) w_next_state = (!r_write && r_status == STAT_OK) ? S_RESP_DATA : S_IDLE;
        w_drop = bus.rx_valid;
      end
      S_RESP_DATA: begin
        if (bus.tx_ready) w_next_state = S_IDLE;
        w_drop = bus.rx_valid;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bus strobes decode straight from the state register so reset drops them asynchronously.
  always_comb begin
    bus.PSEL     = 1'b0;
    bus.PENABLE  = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    unique case (r_state)
      S_SETUP:     bus.PSEL = 1'b1;
      S_ACCESS: begin
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
      end
      S_RESP_STAT: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = r_status;
      end
      S_RESP_DATA: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = r_rdata;
      end
      default: ;
    endcase
  end

  assign bus.PADDR  = r_addr;
  assign bus.PWRITE = r_write;
  assign bus.PWDATA = r_wdata;
  assign busy       = (r_state != S_IDLE);
  assign cmd_drop   = r_cmd_drop;

  // NOTE: state-holding registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= 8'h00;
      r_rdata    <= 8'h00;
      r_status   <= 8'h00;
      r_tcnt     <= 16'd0;
      r_cmd_drop <= 1'b0;
    end else begin
      r_cmd_drop <= w_drop;
      if (r_state == S_IDLE && bus.rx_valid) begin
        r_addr  <= bus.rx_data[ADDR_WIDTH-1:0];
        r_write <= bus.rx_data[7];
      end
      if (r_state == S_WAIT_DATA && bus.rx_valid) r_wdata <= bus.rx_data;
      if (w_byte_to) r_status <= STAT_TO;
      if (w_next_state == S_SETUP) begin
        r_tcnt <= 16'd0;
      end else if (r_state == S_ACCESS) begin
        r_tcnt <= r_tcnt + 16'd1;
      end
      if (r_state == S_ACCESS) begin
        if (bus.PREADY) begin
          r_rdata  <= bus.PRDATA;
          r_status <= bus.PSLVERR ? STAT_ERR : STAT_OK;
        end else if (w_access_to) begin
          r_status <= STAT_TO;
        end
      end
    end
  end

endmodule

// File: doc/apb_uart_cmd_master.md
Name: apb_uart_cmd_master

Overview:
Byte-command APB initiator, the master-side counterpart of the UART APB slave. It turns a byte stream from a UART receiver into single APB read/write transfers, and returns status and read-data bytes to a UART transmitter. It sits between the serial debug port and the SoC APB bus, so a host PC can peek and poke APB registers.

Parameters:
ADDR_WIDTH, 5, width of PADDR; legal range 1..7; PADDR = cmd[ADDR_WIDTH-1:0].
TIMEOUT_CYCLES, 255, max ACCESS cycles waiting for PREADY; 0 disables the timeout; counter width is 16 bits.
BYTE_TIMEOUT, 1000, max cycles between command byte and data byte; used only with the optional feature.

Ports:
PCLK  in  1  clock; all logic is on the rising edge.
PRESET  in  1  asynchronous, active-high reset.
rx_data  in  8  byte from the UART receiver.
rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle; no backpressure.
tx_data  out  8  response byte to the UART transmitter.
tx_valid  out  1  response byte is valid.
tx_ready  in  1  transmitter accepts a byte when tx_valid && tx_ready.
PADDR  out  ADDR_WIDTH  APB address.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction; 1 = write.
PWDATA  out  8  APB write data.
PRDATA  in  8  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB slave error.
busy  out  1  high in every state except IDLE.
cmd_drop  out  1  one-cycle pulse when an rx byte is discarded.

Behaviour:
- Reset (async, PRESET=1): state IDLE. All outputs are 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_valid, tx_data, busy, cmd_drop.
- Command byte format: bit7 = write, bits6:ADDR_WIDTH ignored, bits[ADDR_WIDTH-1:0] = address. A write command is followed by one data byte.
- States: IDLE, WAIT_DATA, SETUP, ACCESS, RESP_STAT, RESP_DATA.
- IDLE, on rx_valid:
  - Latch the address and the write bit.
  - Write -> WAIT_DATA.
  - Read -> SETUP.
- WAIT_DATA, on rx_valid: latch PWDATA -> SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0; PADDR, PWRITE and PWDATA are driven. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1; the timeout counter increments each cycle.
  - PREADY=1: capture PRDATA and PSLVERR; deassert PSEL and PENABLE on the next edge -> RESP_STAT.
  - Timeout: counter reaches TIMEOUT_CYCLES with PREADY still 0 -> abort, deassert PSEL and PENABLE, status = timeout -> RESP_STAT.
- Minimum transfer is 2 cycles (SETUP + ACCESS with PREADY=1). PADDR, PWRITE and PWDATA hold stable from SETUP until the transfer completes, and hold their last value afterwards.
- Status byte values: 0x06 = OK, 0x15 = PSLVERR, 0x18 = timeout.
- RESP_STAT: tx_valid=1, tx_data=status. On tx_ready:
  - Read with status OK -> RESP_DATA.
  - Otherwise -> IDLE.
  - A read that ends in error or timeout sends no data byte.
- RESP_DATA: tx_valid=1, tx_data=captured PRDATA; on tx_ready -> IDLE.
- tx_data holds stable while tx_valid && !tx_ready. tx_valid drops in the cycle after acceptance unless a next byte follows (RESP_STAT -> RESP_DATA is back-to-back).
- rx_valid in SETUP, ACCESS, RESP_STAT or RESP_DATA: the byte is discarded and cmd_drop pulses for 1 cycle. The state is unaffected.
- PSLVERR is sampled only when PREADY=1 in ACCESS.
- Reset asserted mid-transfer: PSEL and PENABLE drop asynchronously; no response byte is sent.
- The timeout counter clears on entry to SETUP.
- TIMEOUT_CYCLES=0: ACCESS waits indefinitely.

Optional Feature:
APB_CMD_BYTE_TIMEOUT_EN
- Defined: in WAIT_DATA a 16-bit counter counts cycles without rx_valid. On reaching BYTE_TIMEOUT:
  - Return to IDLE with no APB transfer.
  - Pulse cmd_drop.
  - Emit status 0x18 through RESP_STAT.
- Not defined: WAIT_DATA waits indefinitely; the counter logic is absent.

Test Plan:
- Write: rx 0x83 then 0x5A, PREADY=1 immediately -> one SETUP cycle with PADDR=3, PWRITE=1, PWDATA=0x5A; then one ACCESS cycle; then tx byte 0x06.
- Read with wait states: rx 0x02, PREADY low for 3 ACCESS cycles, PRDATA=0xC3 -> PSEL held for 5 cycles total; tx bytes 0x06 then 0xC3.
- Slave error: rx 0x01, PREADY=1 with PSLVERR=1 -> tx byte 0x15 only, then busy=0.
- Timeout: TIMEOUT_CYCLES=4, rx 0x04, PREADY held 0 -> PSEL drops after 4 ACCESS cycles; tx byte 0x18.
- Backpressure and drop: tx_ready held 0 for 10 cycles during a read response while rx 0xFF arrives -> tx_data held at 0x06; cmd_drop pulses once; 0xC3 follows after acceptance.
- Reset mid-ACCESS: assert PRESET -> PSEL, PENABLE and tx_valid drop in the same cycle. After release, rx 0x00 runs a normal read.
